// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: two write ports, two read ports, watch tap and status.
interface register_bank_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
);
   localparam int unsigned AW = $clog2(NREGS);

   logic            writeRegister0;
   logic            writeRegister1;
   logic [AW-1:0]   rd0;
   logic [AW-1:0]   rd1;
   logic [XLEN-1:0] dataToWrite0;
   logic [XLEN-1:0] dataToWrite1;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [XLEN-1:0] registerRead1;
   logic [XLEN-1:0] registerRead2;
   logic [XLEN-1:0] watch;
   logic            busy;
   logic            writeDropped;

   modport master (
      output writeRegister0, writeRegister1, rd0, rd1, dataToWrite0, dataToWrite1, rs1, rs2,
      input  registerRead1, registerRead2, watch, busy, writeDropped
   );

   modport slave (
      input  writeRegister0, writeRegister1, rd0, rd1, dataToWrite0, dataToWrite1, rs1, rs2,
      output registerRead1, registerRead2, watch, busy, writeDropped
   );
endinterface

// File: rtl/register_bank.sv
// Two-write / two-read register file with a post-reset initialisation sweep.
// Optional same-cycle write-to-read bypass: define REGISTER_BANK_BYPASS_EN.
module register_bank #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NREGS       = 32,
   parameter int unsigned SP_INDEX    = 2,
   parameter logic [31:0] SP_INIT     = 32'h3fc,
   parameter int unsigned WATCH_INDEX = 18
) (
   input logic            clock,
   input logic            resetN,
   register_bank_if.slave bus
);
   localparam int unsigned AW = $clog2(NREGS);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_count;
   logic [AW-1:0]   w_count_nxt;
   logic [XLEN-1:0] r_regs [0:NREGS-1];

   logic            w_sweep_we;
   logic            w_ready;
   logic [XLEN-1:0] w_sweep_data;
   logic [XLEN-1:0] w_read1;
   logic [XLEN-1:0] w_read2;
   logic [XLEN-1:0] w_watch;

   // State and sweep counter
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state <= ST_INIT;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      case (r_state)
         ST_INIT: begin
            w_count_nxt = r_count + AW'(1);
            if (r_count == AW'(NREGS - 1)) begin
               w_state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            w_state_nxt = ST_READY;
         end
      endcase
   end

   assign w_ready      = (r_state == ST_READY);
   assign w_sweep_we   = (r_state == ST_INIT) && resetN;
   assign w_sweep_data = (r_count == AW'(SP_INDEX)) ? XLEN'(SP_INIT) : '0;

   // Storage is deliberately not reset: the sweep owns initialisation. Entry 0 is never written.
   always_ff @(posedge clock) begin
      for (int i = 1; i < int'(NREGS); i++) begin
         if (w_sweep_we) begin
            if (r_count == AW'(i)) begin
               r_regs[i] <= w_sweep_data;
            end
         end else if (w_ready) begin
            if (bus.writeRegister1 && (bus.rd1 == AW'(i))) begin
               r_regs[i] <= bus.dataToWrite1;
            end else if (bus.writeRegister0 && (bus.rd0 == AW'(i))) begin
               r_regs[i] <= bus.dataToWrite0;
            end
         end
      end
   end

   // Read ports; everything reads 0 until the sweep is done
   always_comb begin
      w_read1 = '0;
      w_read2 = '0;
      w_watch = '0;
      if (w_ready) begin
         w_read1 = (bus.rs1 == '0) ? '0 : r_regs[bus.rs1];
         w_read2 = (bus.rs2 == '0) ? '0 : r_regs[bus.rs2];
         w_watch = (AW'(WATCH_INDEX) == '0) ? '0 : r_regs[AW'(WATCH_INDEX)];
`ifdef REGISTER_BANK_BYPASS_EN
         if (bus.rs1 != '0) begin
            if (bus.writeRegister1 && (bus.rd1 == bus.rs1)) begin
               w_read1 = bus.dataToWrite1;
            end else if (bus.writeRegister0 && (bus.rd0 == bus.rs1)) begin
               w_read1 = bus.dataToWrite0;
            end
         end
         if (bus.rs2 != '0) begin
            if (bus.writeRegister1 && (bus.rd1 == bus.rs2)) begin
               w_read2 = bus.dataToWrite1;
            end else if (bus.writeRegister0 && (bus.rd0 == bus.rs2)) begin
               w_read2 = bus.dataToWrite0;
            end
         end
`endif
      end
   end

   assign bus.registerRead1 = w_read1;
   assign bus.registerRead2 = w_read2;
   assign bus.watch         = w_watch;
   assign bus.busy          = (r_state == ST_INIT);
   // Held low while resetN is low so no spurious pulse appears during reset
   assign bus.writeDropped  = resetN && (r_state == ST_INIT) &&
                              (bus.writeRegister0 || bus.writeRegister1);

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: sweep timing, table vectors, corner sequences, random traffic.
module tb_register_bank;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned NREGS    = 32;
   localparam int unsigned AW       = 5;
   localparam int unsigned SP_IDX   = 2;
   localparam int unsigned WATCH_IX = 18;
   localparam logic [31:0] SP_VAL   = 32'h3fc;

   logic clock = 1'b0;
   logic resetN = 1'b0;
   always #5 clock = ~clock;

   register_bank_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

   register_bank #(
      .XLEN(XLEN), .NREGS(NREGS), .SP_INDEX(SP_IDX), .SP_INIT(SP_VAL), .WATCH_INDEX(WATCH_IX)
   ) dut (
      .clock (clock),
      .resetN(resetN),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] model [NREGS];
   logic            c_we0, c_we1;
   logic [AW-1:0]   c_rd0, c_rd1, c_rs1, c_rs2;
   logic [XLEN-1:0] c_d0, c_d1;

   typedef struct {
      logic          we0;
      logic [AW-1:0] rd0;
      logic [31:0]   d0;
      logic          we1;
      logic [AW-1:0] rd1;
      logic [31:0]   d1;
      logic [AW-1:0] rs1;
      logic [31:0]   exp1;
      logic [AW-1:0] rs2;
      logic [31:0]   exp2;
   } vec_t;
   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we0, input logic [AW-1:0] rd0, input logic [31:0] d0,
                        input logic we1, input logic [AW-1:0] rd1, input logic [31:0] d1,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
      c_we0 = we0; c_rd0 = rd0; c_d0 = d0;
      c_we1 = we1; c_rd1 = rd1; c_d1 = d1;
      c_rs1 = rs1; c_rs2 = rs2;
      bus.writeRegister0 = we0; bus.rd0 = rd0; bus.dataToWrite0 = d0;
      bus.writeRegister1 = we1; bus.rd1 = rd1; bus.dataToWrite1 = d1;
      bus.rs1 = rs1; bus.rs2 = rs2;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic void model_init();
      for (int i = 0; i < int'(NREGS); i++) model[i] = (i == int'(SP_IDX)) ? SP_VAL : 32'h0;
   endfunction

   // Expected read for the currently driven inputs; bypass only changes same-cycle reads
   function automatic logic [31:0] exp_read(input logic [AW-1:0] idx);
      logic [31:0] v;
      if (idx == '0) return 32'h0;
      v = model[idx];
`ifdef REGISTER_BANK_BYPASS_EN
      if (c_we1 && c_rd1 == idx) v = c_d1;
      else if (c_we0 && c_rd0 == idx) v = c_d0;
`endif
      return v;
   endfunction

   function automatic void model_commit();
      if (c_we0 && c_rd0 != '0) model[c_rd0] = c_d0;
      if (c_we1 && c_rd1 != '0) model[c_rd1] = c_d1;
   endfunction

   // Walk a full sweep: busy for exactly NREGS cycles, reads masked, drops flagged
   task automatic run_sweep(input string tag, input logic drop_exp);
      for (int k = 0; k < int'(NREGS); k++) begin
         #1;
         check($sformatf("%s busy c%0d", tag, k), 32'(bus.busy), 32'h1);
         check($sformatf("%s drop c%0d", tag, k), 32'(bus.writeDropped), 32'(drop_exp));
         check($sformatf("%s rd1 c%0d", tag, k), bus.registerRead1, 32'h0);
         check($sformatf("%s watch c%0d", tag, k), bus.watch, 32'h0);
         @(posedge clock);
      end
      #2;
      check({tag, " busy done"}, 32'(bus.busy), 32'h0);
      check({tag, " drop done"}, 32'(bus.writeDropped), 32'h0);
   endtask

   task automatic readback_all(input string tag);
      for (int i = 0; i < int'(NREGS); i++) begin
         drive(1'b0, '0, '0, 1'b0, '0, '0, AW'(i), AW'(NREGS - 1 - i));
         #1;
         check($sformatf("%s r%0d", tag, i), bus.registerRead1, exp_read(AW'(i)));
         check($sformatf("%s r%0d p2", tag, NREGS - 1 - i), bus.registerRead2,
               exp_read(AW'(NREGS - 1 - i)));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 5'd5, 32'hAAAA_0001, 1'b1, 5'd5, 32'h5555_0002, 5'd5, 32'h5555_0002, 5'd2, 32'h0000_03fc};
      vecs[1] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,         5'd0, 32'h0,         5'd5, 32'h5555_0002};
      vecs[2] = '{1'b1, 5'd7, 32'h0000_0077, 1'b1, 5'd0, 32'h1111_1111, 5'd7, 32'h0000_0077, 5'd0, 32'h0};
      vecs[3] = '{1'b1, 5'd2, 32'h0000_0100, 1'b1, 5'd3, 32'h0000_0300, 5'd2, 32'h0000_0100, 5'd3, 32'h0000_0300};
      vecs[4] = '{1'b0, 5'd9, 32'hDEAD_0000, 1'b0, 5'd10, 32'hBEEF_0000, 5'd9, 32'h0,        5'd10, 32'h0};
      vecs[5] = '{1'b1, 5'd31, 32'hCAFE_0000, 1'b1, 5'd30, 32'hBEEF_0001, 5'd31, 32'hCAFE_0000, 5'd30, 32'hBEEF_0001};
      vecs[6] = '{1'b1, 5'd6, 32'h0000_0600, 1'b1, 5'd6, 32'h0,         5'd6, 32'h0,         5'd7, 32'h0000_0077};

      // Reset held with a write request: drop must stay low, reads masked
      drive(1'b1, 5'd4, 32'h4444, 1'b0, '0, '0, 5'd2, 5'd18);
      repeat (3) @(posedge clock);
      #2;
      check("reset busy", 32'(bus.busy), 32'h1);
      check("reset drop", 32'(bus.writeDropped), 32'h0);
      check("reset rd1", bus.registerRead1, 32'h0);
      drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd2, 5'd18);
      @(posedge clock);
      #1 resetN = 1'b1;
      run_sweep("sweep0", 1'b0);
      model_init();
      readback_all("init");

      // Table vectors: write on one edge, read back after it
      foreach (vecs[v]) begin
         drive(vecs[v].we0, vecs[v].rd0, vecs[v].d0, vecs[v].we1, vecs[v].rd1, vecs[v].d1, '0, '0);
         #1;
         check($sformatf("vec%0d drop", v), 32'(bus.writeDropped), 32'h0);
         model_commit();
         tick();
         drive(1'b0, '0, '0, 1'b0, '0, '0, vecs[v].rs1, vecs[v].rs2);
         #1;
         check($sformatf("vec%0d rs1", v), bus.registerRead1, vecs[v].exp1);
         check($sformatf("vec%0d rs2", v), bus.registerRead2, vecs[v].exp2);
      end

      // Same-cycle read of index 0 while writing it
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      #1;
      check("r0 same-cycle", bus.registerRead1, 32'h0);
      tick();

      // Watch register: same-cycle vs next-cycle visibility
      drive(1'b1, 5'd18, 32'h5A5A, 1'b0, '0, '0, '0, '0);
      model_commit();
      tick();
      drive(1'b1, 5'd18, 32'h1234, 1'b0, '0, '0, 5'd0, 5'd18);
      #1;
`ifdef REGISTER_BANK_BYPASS_EN
      check("r18 same-cycle", bus.registerRead2, 32'h1234);
`else
      check("r18 same-cycle", bus.registerRead2, 32'h5A5A);
`endif
      check("watch pre-edge", bus.watch, 32'h5A5A);
      model_commit();
      tick();
      drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd0, 5'd18);
      #1;
      check("r18 after edge", bus.registerRead2, 32'h1234);
      check("watch after edge", bus.watch, 32'h1234);

      // Random traffic against the model
      for (int n = 0; n < 300; n++) begin
         logic          we0, we1;
         logic [AW-1:0] rd0, rd1, rs1, rs2;
         we0 = 1'($urandom);
         we1 = 1'($urandom);
         rd0 = AW'($urandom);
         rd1 = ($urandom_range(0, 3) == 0) ? rd0 : AW'($urandom);
         rs1 = ($urandom_range(0, 2) == 0) ? rd0 : AW'($urandom);
         rs2 = ($urandom_range(0, 2) == 0) ? rd1 : AW'($urandom);
         drive(we0, rd0, $urandom, we1, rd1, $urandom, rs1, rs2);
         #1;
         check($sformatf("rnd%0d rs1", n), bus.registerRead1, exp_read(rs1));
         check($sformatf("rnd%0d rs2", n), bus.registerRead2, exp_read(rs2));
         check($sformatf("rnd%0d watch", n), bus.watch, model[WATCH_IX]);
         check($sformatf("rnd%0d busy", n), 32'(bus.busy), 32'h0);
         check($sformatf("rnd%0d drop", n), 32'(bus.writeDropped), 32'h0);
         model_commit();
         tick();
      end

      // Reset pulse at sweep cycle 10 with a write held: sweep restarts, write never lands
      resetN = 1'b0;
      #1;
      check("mid reset busy", 32'(bus.busy), 32'h1);
      tick();
      resetN = 1'b1;
      drive(1'b1, 5'd3, 32'h0000_0BAD, 1'b0, '0, '0, 5'd3, 5'd18);
      for (int k = 0; k < 10; k++) begin
         #1;
         check($sformatf("pre busy c%0d", k), 32'(bus.busy), 32'h1);
         check($sformatf("pre drop c%0d", k), 32'(bus.writeDropped), 32'h1);
         @(posedge clock);
         #1;
      end
      resetN = 1'b0;
      #1;
      check("pulse busy", 32'(bus.busy), 32'h1);
      check("pulse drop", 32'(bus.writeDropped), 32'h0);
      #1 resetN = 1'b1;
      run_sweep("sweep1", 1'b1);
      model_init();
      readback_all("reinit");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
